// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the shared byte-wide RAM port: registered req/ack/rvalid
// handshake, one transaction in flight, round-robin or fixed A-priority.
module ram_arbiter #(
   parameter int ADDR_WIDTH     = 18,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  a_enable,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [7:0]            a_wdata,
   output logic                  a_ack,
   output logic [7:0]            a_rdata,
   output logic                  a_rvalid,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [7:0]            b_wdata,
   output logic                  b_ack,
   output logic [7:0]            b_rdata,
   output logic                  b_rvalid,
   output logic                  ram_write,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic [7:0]            ram_data_in,
   input  logic [7:0]            ram_data_out
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

   state_t                  state, state_next;
   sel_t                    sel;   // owner of the current/last transaction, i.e. last_grant
   sel_t                    grant;
   logic                    grant_valid;
   logic                    a_elig, b_elig;
   logic                    lat_we;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [7:0]              lat_wdata;

   assign a_elig = a_req & a_enable;
   assign b_elig = b_req;

   always_ff @(posedge CLK) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next  = state;
      grant       = SEL_A;
      grant_valid = 1'b0;
      case (state)
         IDLE: begin
            if (a_elig || b_elig) begin
               grant_valid = 1'b1;
               state_next  = ISSUE;
               if (a_elig && b_elig)
                  grant = (FIXED_PRIORITY || sel == SEL_B) ? SEL_A : SEL_B;
               else
                  grant = a_elig ? SEL_A : SEL_B;
            end
         end
         ISSUE:   state_next = lat_we ? IDLE : WAIT;
         WAIT:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request fields are captured once at grant; later changes by the requester are ignored.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         sel       <= SEL_B;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= 8'h00;
      end else if (grant_valid) begin
         sel       <= grant;
         lat_we    <= (grant == SEL_A) ? a_we    : b_we;
         lat_addr  <= (grant == SEL_A) ? a_addr  : b_addr;
         lat_wdata <= (grant == SEL_A) ? a_wdata : b_wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= 8'h00;
         b_rdata  <= 8'h00;
      end else begin
         a_rvalid <= (state == WAIT) && (sel == SEL_A);
         b_rvalid <= (state == WAIT) && (sel == SEL_B);
         if (state == WAIT && sel == SEL_A) a_rdata <= ram_data_out;
         if (state == WAIT && sel == SEL_B) b_rdata <= ram_data_out;
      end
   end

   always_comb begin
      a_ack     = 1'b0;
      b_ack     = 1'b0;
      ram_write = 1'b0;
      if (state == ISSUE) begin
         a_ack     = (sel == SEL_A);
         b_ack     = (sel == SEL_B);
         ram_write = lat_we;
      end
   end

   // Address/data follow the latched request, so they hold their last value while idle.
   assign ram_waddr   = lat_addr;
   assign ram_raddr   = lat_addr;
   assign ram_data_in = lat_wdata;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single byte-wide RAM port (bram/spram bank decode sits downstream) between two requesters: A (cpu) and B (monitor loader/dumper).
- Replaces the static `running` mux with a registered req/ack/rvalid handshake.
- Gives both requesters safe concurrent access, so the monitor can dump memory while the cpu runs.
- One transaction in flight at a time. Round-robin or fixed-priority arbitration.

Parameters:
- ADDR_WIDTH, 18: byte address width of the RAM port.
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = A always wins when both request.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-low
- a_enable  in  1  when low, a_req is ignored (cpu halted)
- a_req  in  1  A requests access; held with a_we/a_addr/a_wdata stable until a_ack
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  byte address
- a_wdata  in  8  write data
- a_ack  out  1  one-cycle pulse: request accepted
- a_rdata  out  8  read data, valid while a_rvalid
- a_rvalid  out  1  one-cycle pulse: read data valid
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_rvalid: identical to the A set (no enable)
- ram_write  out  1  RAM write strobe
- ram_waddr  out  ADDR_WIDTH  RAM write address
- ram_raddr  out  ADDR_WIDTH  RAM read address
- ram_data_in  out  8  RAM write data
- ram_data_out  in  8  RAM read data, 1-cycle registered latency

Behaviour:
- Reset (reset==0 at edge):
  - All outputs are 0; state = IDLE; last_grant = B, so A wins the first contention.
  - Any in-flight transaction is abandoned: no ack or rvalid is produced afterwards, and ram_write is 0 from the next cycle.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Eligible requests are a_req&a_enable and b_req.
  - If none is eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible: with FIXED_PRIORITY=1 grant A; otherwise grant the requester that is not last_grant.
  - On grant: latch sel, we, addr, wdata into registers; set last_grant = sel; assert x_ack next cycle; go to ISSUE.
- ISSUE (1 cycle):
  - ram_waddr = ram_raddr = latched addr; ram_data_in = latched wdata; ram_write = latched we.
  - x_ack is high this cycle only.
  - Write: go to IDLE. Read: go to WAIT.
- WAIT (1 cycle):
  - Capture ram_data_out into x_rdata; assert x_rvalid next cycle (that cycle is IDLE).
  - Go to IDLE.
- Latency from the edge at which req is sampled (edge 0):
  - ack in cycle 1.
  - Write reaches RAM at edge 2.
  - Read: rvalid/rdata in cycle 3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- RAM port outputs hold their last value in IDLE; ram_write is 0 outside ISSUE.
- Handshake rules:
  - The requester deasserts req, or presents a new transaction, at the edge after ack.
  - A req still high at that edge is treated as a new request.
  - Request fields are latched at grant, so changes after grant have no effect.
  - Dropping req before ack is legal; the request is withdrawn only if not yet granted.
- x_rdata holds its value until the next read completes for that requester.
- Only the granted requester sees ack/rvalid; the other's outputs stay 0.
- a_enable falling while A is granted does not cancel the in-flight transaction.
- rvalid (cycle 3) and a new grant's ack can coincide: IDLE grants in the same cycle it outputs rvalid.

Test Plan:
- Reset, then A write: a_req=1, a_we=1, a_addr=0x00100, a_wdata=0x5A -> a_ack in cycle 1; ram_write=1, ram_waddr=0x00100, ram_data_in=0x5A in cycle 1 only; b_ack stays 0.
- B read: b_addr=0x20000, RAM model returns 0xC3 -> b_ack cycle 1, b_rvalid cycle 3, b_rdata=0xC3; ram_write never asserted.
- Contention, FIXED_PRIORITY=0: both hold req continuously, each dropping for the cycle after its ack -> grants alternate A,B,A,B starting with A; no requester waits more than one transaction.
- FIXED_PRIORITY=1, both request -> A granted every time; B granted only after A drops req. a_enable=0 -> B granted immediately.
- Reset pulse during WAIT of a read -> no rvalid; all outputs 0 the cycle after reset; a subsequent request completes normally.
- Back-to-back reads by A to addresses 0x3FFFF then 0x00000 -> rdata matches the RAM model for each; rvalid at cycles 3 and 6; no address wrap artifacts.
